// File: rtl/load_store_unit_if.sv
// Load/store unit bus bundle.
// Carries the MEM-stage request/response handshake and the word-organised
// data memory port.
//   slave  : the load/store unit itself. It accepts requests, returns
//            responses and drives the memory strobes.
//   master : the environment, i.e. the pipeline plus the data memory.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    // request from the pipeline
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    // response to the pipeline
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_fault;
    // data memory port
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_write_data;
    logic                  mem_write;
    logic                  mem_read;
    logic [31:0]           mem_read_data;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_fault,
        input  resp_ready,
        output mem_address, mem_write_data, mem_write, mem_read,
        input  mem_read_data
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_fault,
        output resp_ready,
        input  mem_address, mem_write_data, mem_write, mem_read,
        output mem_read_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit for the MEM stage.
// It handles one request at a time. Byte, halfword and word accesses are
// performed on a word-organised memory. Sub-word stores use read-modify-write,
// and loads are sign- or zero-extended.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : load_store_unit_if.slave
//           req_* / resp_* handshake and the mem_* port
module load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    load_store_unit_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic                  write_q;
    logic                  signed_q;
    logic [31:0]           wword_q;  // store data; becomes the merged word after READ
    logic [31:0]           rdata_q;
    logic                  fault_q;

    logic        accept;
    logic        fault_in;
    logic        word_store_in;
    logic [31:0] lane_shift;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign accept = bus.req_valid && (state_q == IDLE);

    // Faults are decided on the incoming request, so a faulting access never
    // reaches the memory strobes.
    assign fault_in = (bus.req_size == 2'b11) ||
                      (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                      (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

    assign word_store_in = bus.req_write && (bus.req_size == 2'b10);

    // Move the addressed lane down to bit 0. Halfwords are 2-aligned, so the
    // same shift also serves them.
    assign lane_shift = bus.mem_read_data >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = bus.mem_read_data;
        case (size_q)
            2'b00:   load_ext = signed_q ? {{24{lane_shift[7]}}, lane_shift[7:0]}
                                         : {24'h0, lane_shift[7:0]};
            2'b01:   load_ext = signed_q ? {{16{lane_shift[15]}}, lane_shift[15:0]}
                                         : {16'h0, lane_shift[15:0]};
            default: load_ext = bus.mem_read_data;
        endcase
    end

    // The old word with only the target lane replaced. wword_q still holds
    // the right-justified store data while the state is READ.
    always_comb begin
        merged = bus.mem_read_data;
        if (size_q == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wword_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wword_q[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d            = state_q;
        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_address    = '0;
        bus.mem_write_data = '0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (accept) begin
                    if (fault_in)           state_d = RESP;
                    else if (word_store_in) state_d = WRITE;
                    else                    state_d = READ;
                end
            end
            READ: begin
                bus.mem_read    = 1'b1;
                bus.mem_address = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                state_d         = write_q ? WRITE : RESP;
            end
            WRITE: begin
                bus.mem_write      = 1'b1;
                bus.mem_address    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                bus.mem_write_data = wword_q;
                state_d            = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            size_q   <= 2'b00;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            wword_q  <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else if (accept) begin
            addr_q   <= bus.req_addr;
            size_q   <= bus.req_size;
            write_q  <= bus.req_write;
            signed_q <= bus.req_signed;
            wword_q  <= bus.req_wdata;
            rdata_q  <= '0;
            fault_q  <= fault_in;
        end else if (state_q == READ) begin
            if (write_q) wword_q <= merged;
            else         rdata_q <= load_ext;
        end
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_fault = fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_WIDTH(32)) ifc ();
    load_store_unit #(.ADDR_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

    logic [31:0] mem [0:63];
    assign ifc.mem_read_data = mem[ifc.mem_address[7:2]];
    always @(posedge clk)
        if (ifc.mem_write) mem[ifc.mem_address[7:2]] <= ifc.mem_write_data;

    int          wr_cnt = 0, rd_cnt = 0, overlap = 0;
    logic [31:0] last_waddr = '0, last_wdata = '0;
    always @(negedge clk) begin
        if (ifc.mem_write) begin
            wr_cnt++;
            last_waddr = ifc.mem_address;
            last_wdata = ifc.mem_write_data;
        end
        if (ifc.mem_read) rd_cnt++;
        if (ifc.mem_read && ifc.mem_write) overlap++;
    end

    int checks = 0, passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts just after a rising edge with the unit in IDLE. It returns just
    // after the edge that completes the response handshake.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic flt, output int lat);
        ifc.req_valid = 1'b1; ifc.req_write = w; ifc.req_size = sz;
        ifc.req_signed = sg; ifc.req_addr = a; ifc.req_wdata = d;
        @(posedge clk); #1;
        ifc.req_valid = 1'b0; ifc.req_wdata = 32'hDEAD_BEEF;
        lat = 1;
        while (!ifc.resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = ifc.resp_rdata;
        flt = ifc.resp_fault;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        flt;
    int          lat, w0, r0, seen;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        ifc.req_valid = 0; ifc.req_write = 0; ifc.req_size = 0; ifc.req_signed = 0;
        ifc.req_addr = 0; ifc.req_wdata = 0; ifc.resp_ready = 1;
        #12;
        chk("rst_req_ready", 32'(ifc.req_ready), 1);
        chk("rst_resp_valid", 32'(ifc.resp_valid), 0);
        chk("rst_strobes", {30'b0, ifc.mem_read, ifc.mem_write}, 0);
        chk("rst_mem_address", ifc.mem_address, 0);
        chk("rst_mem_wdata", ifc.mem_write_data, 0);
        chk("rst_resp_rdata", ifc.resp_rdata, 0);
        chk("rst_resp_fault", 32'(ifc.resp_fault), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // word store then word load
        w0 = wr_cnt; r0 = rd_cnt;
        do_req(1, 2'b10, 0, 32'h4, 32'h1234_5678, rd, flt, lat);
        chk("wst_lat", lat, 2);
        chk("wst_writes", wr_cnt - w0, 1);
        chk("wst_reads", rd_cnt - r0, 0);
        chk("wst_addr", last_waddr, 32'h4);
        chk("wst_data", last_wdata, 32'h1234_5678);
        chk("wst_rdata", rd, 0);
        r0 = rd_cnt;
        do_req(0, 2'b10, 1, 32'h4, 0, rd, flt, lat);
        chk("wld_rdata", rd, 32'h1234_5678);
        chk("wld_lat", lat, 2);
        chk("wld_reads", rd_cnt - r0, 1);

        // byte read-modify-write
        do_req(1, 2'b10, 0, 32'h8, 32'h8765_4321, rd, flt, lat);
        w0 = wr_cnt; r0 = rd_cnt;
        do_req(1, 2'b00, 0, 32'h9, 32'h0000_00AB, rd, flt, lat);
        chk("bst_lat", lat, 3);
        chk("bst_reads", rd_cnt - r0, 1);
        chk("bst_writes", wr_cnt - w0, 1);
        chk("bst_data", last_wdata, 32'h8765_AB21);
        do_req(0, 2'b00, 1, 32'h9, 0, rd, flt, lat);
        chk("lb_signed", rd, 32'hFFFF_FFAB);
        do_req(0, 2'b00, 0, 32'h9, 0, rd, flt, lat);
        chk("lb_unsigned", rd, 32'h0000_00AB);
        do_req(0, 2'b00, 0, 32'hB, 0, rd, flt, lat);
        chk("lb_lane3", rd, 32'h0000_0087);

        // halfword store on the upper half of a zero word
        do_req(1, 2'b01, 0, 32'hE, 32'h1234_BEEF, rd, flt, lat);
        chk("hst_lat", lat, 3);
        chk("hst_data", last_wdata, 32'hBEEF_0000);
        do_req(0, 2'b10, 0, 32'hC, 0, rd, flt, lat);
        chk("hst_word", rd, 32'hBEEF_0000);
        do_req(0, 2'b01, 1, 32'hE, 0, rd, flt, lat);
        chk("lh_signed", rd, 32'hFFFF_BEEF);
        do_req(0, 2'b01, 0, 32'hC, 0, rd, flt, lat);
        chk("lh_low_zero", rd, 32'h0);

        // faults
        w0 = wr_cnt; r0 = rd_cnt;
        do_req(0, 2'b01, 1, 32'h5, 0, rd, flt, lat);
        chk("flt_half_fault", 32'(flt), 1);
        chk("flt_half_rdata", rd, 0);
        chk("flt_half_lat", lat, 1);
        do_req(1, 2'b10, 0, 32'h6, 32'hFFFF_FFFF, rd, flt, lat);
        chk("flt_word_fault", 32'(flt), 1);
        chk("flt_word_lat", lat, 1);
        do_req(0, 2'b11, 0, 32'h0, 0, rd, flt, lat);
        chk("flt_size_fault", 32'(flt), 1);
        chk("flt_size_rdata", rd, 0);
        chk("flt_size_lat", lat, 1);
        chk("flt_no_strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);
        do_req(0, 2'b10, 0, 32'h4, 0, rd, flt, lat);
        chk("post_fault_clear", 32'(flt), 0);

        // back-pressure on a load
        ifc.resp_ready = 1'b0;
        ifc.req_valid = 1; ifc.req_write = 0; ifc.req_size = 2'b10; ifc.req_addr = 32'h4;
        @(posedge clk); #1; ifc.req_valid = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(ifc.resp_valid), 1);
            chk("bp_rdata", ifc.resp_rdata, 32'h1234_5678);
            chk("bp_idle", {29'b0, ifc.req_ready, ifc.mem_read, ifc.mem_write}, 0);
            @(posedge clk); #1;
        end
        ifc.resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {30'b0, ifc.req_ready, ifc.resp_valid}, 32'b10);

        // reset during the READ of a byte store
        w0 = wr_cnt;
        ifc.req_valid = 1; ifc.req_write = 1; ifc.req_size = 2'b00;
        ifc.req_addr = 32'h9; ifc.req_wdata = 32'hCD;
        @(posedge clk); #1; ifc.req_valid = 0;
        chk("abort_in_read", 32'(ifc.mem_read), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_strobes", {30'b0, ifc.mem_read, ifc.mem_write}, 0);
        chk("abort_addr", ifc.mem_address, 0);
        chk("abort_ready", {30'b0, ifc.req_ready, ifc.resp_valid}, 32'b10);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (ifc.resp_valid) seen++;
        end
        chk("abort_no_resp", seen, 0);
        chk("abort_no_write", wr_cnt - w0, 0);
        chk("abort_mem_kept", mem[2], 32'h8765_AB21);
        chk("no_overlap", overlap, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
